// File: rtl/ipe.sv
// ipe: inverse radix-2 PE, 3-stage valid/ready pipeline (capture, twiddle multiply, add/sub with 1/2 scale).
// Define IPE_SAT_EN to saturate the twiddle product field instead of letting it wrap.
module ipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHIFT = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] tf,
  input  logic             bypass_n,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned PW  = 2 * WIDTH;
  localparam int unsigned TOP = SHIFT + WIDTH - 1;

  logic             advance;
  logic             s1_valid;
  logic             s1_bypass_n;
  logic [WIDTH-1:0] s1_a0, s1_a1, s1_b2, s1_b3, s1_tf;
  logic             s2_valid;
  logic [WIDTH-1:0] s2_a0, s2_a1, s2_m2, s2_m3;
  logic [PW-1:0]    p2, p3;
  logic [WIDTH-1:0] f2_c, f3_c;
  logic [WIDTH:0]   sum0_c, dif1_c, sum2_c, dif3_c;
  logic             unused_prod;

  function automatic logic [PW-1:0] sext(input logic [WIDTH-1:0] v);
    return {{WIDTH{v[WIDTH-1]}}, v};
  endfunction

`ifdef IPE_SAT_EN
  // Clamp when the bits above the field are not a pure sign extension.
  function automatic logic [WIDTH-1:0] sat_field(input logic [PW-1-TOP:0] hi,
                                                 input logic [WIDTH-1:0] field);
    if (hi == '0 || hi == '1) return field;
    if (hi[PW-1-TOP])         return {1'b1, {(WIDTH-1){1'b0}}};
    return {1'b0, {(WIDTH-1){1'b1}}};
  endfunction
`endif

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // Low PW bits of the product of sign-extended operands equal the signed product.
  assign p2 = sext(s1_b2) * sext(s1_tf);
  assign p3 = sext(s1_b3) * sext(s1_tf);
  assign unused_prod = ^{p2, p3};

`ifdef IPE_SAT_EN
  assign f2_c = sat_field(p2[PW-1:TOP], p2[TOP:SHIFT]);
  assign f3_c = sat_field(p3[PW-1:TOP], p3[TOP:SHIFT]);
`else
  assign f2_c = p2[TOP:SHIFT];
  assign f3_c = p3[TOP:SHIFT];
`endif

  assign sum0_c = {s2_a0[WIDTH-1], s2_a0} + {s2_m2[WIDTH-1], s2_m2};
  assign dif1_c = {s2_a0[WIDTH-1], s2_a0} - {s2_m2[WIDTH-1], s2_m2};
  assign sum2_c = {s2_a1[WIDTH-1], s2_a1} + {s2_m3[WIDTH-1], s2_m3};
  assign dif3_c = {s2_a1[WIDTH-1], s2_a1} - {s2_m3[WIDTH-1], s2_m3};

  // All stages shift together; dropping bit 0 of the wide sum is the floor halving.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      s1_valid    <= 1'b0;
      s1_bypass_n <= 1'b0;
      s1_a0       <= '0;
      s1_a1       <= '0;
      s1_b2       <= '0;
      s1_b3       <= '0;
      s1_tf       <= '0;
      s2_valid    <= 1'b0;
      s2_a0       <= '0;
      s2_a1       <= '0;
      s2_m2       <= '0;
      s2_m3       <= '0;
      out_valid   <= 1'b0;
      out0        <= '0;
      out1        <= '0;
      out2        <= '0;
      out3        <= '0;
    end else if (advance) begin
      s1_valid    <= in_valid;
      s1_bypass_n <= bypass_n;
      s1_a0       <= in0;
      s1_a1       <= in1;
      s1_b2       <= in2;
      s1_b3       <= in3;
      s1_tf       <= tf;
      s2_valid    <= s1_valid;
      s2_a0       <= s1_a0;
      s2_a1       <= s1_a1;
      s2_m2       <= s1_bypass_n ? f2_c : s1_b2;
      s2_m3       <= s1_bypass_n ? f3_c : s1_b3;
      out_valid   <= s2_valid;
      out0        <= sum0_c[WIDTH:1];
      out1        <= dif1_c[WIDTH:1];
      out2        <= sum2_c[WIDTH:1];
      out3        <= dif3_c[WIDTH:1];
    end
  end

endmodule
